// File: rtl/mmu_ext_burst_ctrl.sv
// rtl/mmu_ext_burst_ctrl.sv - cache-line to 4-beat mem_ext burst converter
// Serialises writeback lines, assembles refill lines, one response per request.
module mmu_ext_burst_ctrl #(
  parameter int PADDR_WIDTH    = 33,
  parameter int BEAT_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_vld,
  output logic                    o_req_rdy,
  input  logic                    i_req_wr,
  input  logic [PADDR_WIDTH-1:0]  i_req_paddr,
  input  logic [4*BEAT_WIDTH-1:0] i_req_line,
  input  logic [BEAT_WIDTH/2-1:0] i_req_mask,
  output logic                    o_rsp_vld,
  output logic                    o_rsp_wr,
  output logic                    o_rsp_err,
  output logic [4*BEAT_WIDTH-1:0] o_rsp_line,
  output logic                    o_mem_ext_rden,
  output logic                    o_mem_ext_wren,
  output logic [BEAT_WIDTH/8-1:0] o_mem_ext_mask,
  output logic [2:0]              o_mem_ext_burst_size,
  output logic [PADDR_WIDTH-1:0]  o_mem_ext_paddr,
  output logic [BEAT_WIDTH-1:0]   o_mem_ext_wdat,
  output logic                    o_mem_ext_burst_start,
  output logic                    o_mem_ext_burst_end,
  output logic                    o_mem_ext_burst_vld,
  input  logic                    i_ext_mmu_rdy,
  input  logic                    i_ext_mmu_rd_ack,
  input  logic                    i_ext_mmu_wr_ack,
  input  logic [BEAT_WIDTH-1:0]   i_ext_mmu_rdat
);

  localparam int LINE_W = 4 * BEAT_WIDTH;
  localparam int MASK_W = BEAT_WIDTH / 8;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR_BEAT, WR_WAIT, RD_CMD, RD_DATA, RSP} state_t;

  state_t                   state, state_n;
  logic [1:0]               cnt;
  logic [7:0]               tmo;
  logic [PADDR_WIDTH-1:0]   paddr_q;
  logic [LINE_W-1:0]        line_q;
  logic [4*MASK_W-1:0]      mask_q;
  logic                     wr_q;
  logic                     err_q;
  logic [LINE_W-1:0]        rd_buf, rd_buf_d;
  logic [LINE_W-1:0]        rsp_line_q;

  logic beat_fire, cmd_fire, rd_take, progress, counting, expire;

  assign beat_fire = (state == WR_BEAT) && (cnt != 2'd0 || i_ext_mmu_rdy);
  assign cmd_fire  = (state == RD_CMD) && i_ext_mmu_rdy;
  assign rd_take   = (state == RD_DATA) && i_ext_mmu_rd_ack;
  assign progress  = beat_fire || cmd_fire || rd_take ||
                     ((state == WR_WAIT) && i_ext_mmu_wr_ack);
  // Only stalls on the far side count towards the timeout; an ack in the expiry cycle wins.
  assign counting  = ((state == WR_BEAT) && cnt == 2'd0 && !i_ext_mmu_rdy) ||
                     ((state == RD_CMD) && !i_ext_mmu_rdy) ||
                     ((state == RD_DATA) && !i_ext_mmu_rd_ack) ||
                     ((state == WR_WAIT) && !i_ext_mmu_wr_ack);
  assign expire    = counting && (tmo == TMO_LAST);

  always_comb begin
    rd_buf_d = rd_buf;
    if (rd_take) rd_buf_d[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] = i_ext_mmu_rdat;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_req_vld) state_n = i_req_wr ? WR_BEAT : RD_CMD;
      WR_BEAT: if (beat_fire && cnt == 2'd3) state_n = WR_WAIT;
               else if (expire)              state_n = RSP;
      WR_WAIT: if (i_ext_mmu_wr_ack || expire) state_n = RSP;
      RD_CMD:  if (cmd_fire)    state_n = RD_DATA;
               else if (expire) state_n = RSP;
      RD_DATA: if ((rd_take && cnt == 2'd3) || expire) state_n = RSP;
      RSP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 2'd0;
      tmo        <= 8'd0;
      paddr_q    <= '0;
      line_q     <= '0;
      mask_q     <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      rd_buf     <= '0;
      rsp_line_q <= '0;
    end else begin
      if (state == IDLE && i_req_vld) begin
        paddr_q <= {i_req_paddr[PADDR_WIDTH-1:6], 6'b0};
        line_q  <= i_req_line;
        mask_q  <= i_req_mask;
        wr_q    <= i_req_wr;
        cnt     <= 2'd0;
        if (!i_req_wr) rd_buf <= '0;
      end
      if (beat_fire || rd_take) cnt <= cnt + 2'd1;
      if (cmd_fire) cnt <= 2'd0;
      if (rd_take) rd_buf <= rd_buf_d;

      if (state_n != state || progress) tmo <= 8'd0;
      else if (counting)                tmo <= tmo + 8'd1;

      if (state != RSP && state_n == RSP) begin
        err_q <= expire;
        if (!wr_q) rsp_line_q <= rd_buf_d;
      end
    end
  end

  always_comb begin
    o_req_rdy             = (state == IDLE);
    o_rsp_vld             = (state == RSP);
    o_mem_ext_burst_vld   = beat_fire || cmd_fire;
    o_mem_ext_wren        = beat_fire;
    o_mem_ext_rden        = cmd_fire;
    o_mem_ext_burst_start = (beat_fire && cnt == 2'd0) || cmd_fire;
    o_mem_ext_burst_end   = beat_fire && cnt == 2'd3;
  end

  assign o_rsp_wr             = wr_q;
  assign o_rsp_err            = err_q;
  assign o_rsp_line           = (state == RSP && wr_q) ? '0 : rsp_line_q;
  assign o_mem_ext_burst_size = 3'd4;
  assign o_mem_ext_paddr      = paddr_q;
  assign o_mem_ext_wdat       = line_q[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH];
  assign o_mem_ext_mask       = mask_q[int'(cnt)*MASK_W +: MASK_W];

endmodule

// File: tb/tb_mmu_ext_burst_ctrl.sv
// tb/tb_mmu_ext_burst_ctrl.sv - scoreboard bench for mmu_ext_burst_ctrl
module tb_mmu_ext_burst_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req_vld, i_req_wr;
  logic         o_req_rdy;
  logic [32:0]  i_req_paddr;
  logic [511:0] i_req_line;
  logic [63:0]  i_req_mask;
  logic         o_rsp_vld, o_rsp_wr, o_rsp_err;
  logic [511:0] o_rsp_line;
  logic         o_mem_ext_rden, o_mem_ext_wren;
  logic [15:0]  o_mem_ext_mask;
  logic [2:0]   o_mem_ext_burst_size;
  logic [32:0]  o_mem_ext_paddr;
  logic [127:0] o_mem_ext_wdat;
  logic         o_mem_ext_burst_start, o_mem_ext_burst_end, o_mem_ext_burst_vld;
  logic         i_ext_mmu_rdy, i_ext_mmu_rd_ack, i_ext_mmu_wr_ack;
  logic [127:0] i_ext_mmu_rdat;

  mmu_ext_burst_ctrl #(.PADDR_WIDTH(33), .BEAT_WIDTH(128), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_wr(i_req_wr),
    .i_req_paddr(i_req_paddr), .i_req_line(i_req_line), .i_req_mask(i_req_mask),
    .o_rsp_vld(o_rsp_vld), .o_rsp_wr(o_rsp_wr), .o_rsp_err(o_rsp_err), .o_rsp_line(o_rsp_line),
    .o_mem_ext_rden(o_mem_ext_rden), .o_mem_ext_wren(o_mem_ext_wren),
    .o_mem_ext_mask(o_mem_ext_mask), .o_mem_ext_burst_size(o_mem_ext_burst_size),
    .o_mem_ext_paddr(o_mem_ext_paddr), .o_mem_ext_wdat(o_mem_ext_wdat),
    .o_mem_ext_burst_start(o_mem_ext_burst_start), .o_mem_ext_burst_end(o_mem_ext_burst_end),
    .o_mem_ext_burst_vld(o_mem_ext_burst_vld),
    .i_ext_mmu_rdy(i_ext_mmu_rdy), .i_ext_mmu_rd_ack(i_ext_mmu_rd_ack),
    .i_ext_mmu_wr_ack(i_ext_mmu_wr_ack), .i_ext_mmu_rdat(i_ext_mmu_rdat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic         rd;
    logic         st;
    logic         en;
    logic         chkd;
    logic [127:0] wdat;
    logic [15:0]  mask;
    logic [32:0]  paddr;
  } beat_t;

  typedef struct {
    int           cyc;
    logic         wr;
    logic         err;
    logic [511:0] line;
  } rsp_t;

  beat_t bq[$];
  rsp_t  rq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    t0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to(input int c);
    while (cyc < c) tick();
  endtask

  function automatic logic [511:0] mk_line(input logic [127:0] b0, input logic [127:0] b1,
                                           input logic [127:0] b2, input logic [127:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic push_wr(input int t, input logic [32:0] pa, input logic [511:0] ln,
                         input logic [63:0] mk, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.cyc = t + k; b.rd = 1'b0; b.st = (k == 0); b.en = (k == 3); b.chkd = 1'b1;
      b.wdat = ln[k*128 +: 128]; b.mask = mk[k*16 +: 16]; b.paddr = pa;
      bq.push_back(b);
    end
  endtask

  task automatic push_rd(input int t, input logic [32:0] pa);
    beat_t b;
    b.cyc = t; b.rd = 1'b1; b.st = 1'b1; b.en = 1'b0; b.chkd = 1'b0;
    b.wdat = '0; b.mask = '0; b.paddr = pa;
    bq.push_back(b);
  endtask

  task automatic push_rsp(input int t, input logic wr, input logic err, input logic [511:0] ln);
    rsp_t r;
    r.cyc = t; r.wr = wr; r.err = err; r.line = ln;
    rq.push_back(r);
  endtask

  task automatic req(input logic wr, input logic [32:0] pa, input logic [511:0] ln,
                     input logic [63:0] mk);
    i_req_vld = 1'b1; i_req_wr = wr; i_req_paddr = pa; i_req_line = ln; i_req_mask = mk;
  endtask

  task automatic ack(input int c, input logic [127:0] d);
    to(c); i_ext_mmu_rd_ack = 1'b1; i_ext_mmu_rdat = d;
    to(c + 1); i_ext_mmu_rd_ack = 1'b0;
  endtask

  // Monitor: beats and responses are popped only when the DUT presents them.
  always @(negedge clk) begin
    beat_t b;
    rsp_t  r;
    if (o_mem_ext_burst_vld === 1'b1) begin
      if (bq.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        b = bq.pop_front();
        chk("beat_cyc", cyc, b.cyc);
        chk("beat_rden", o_mem_ext_rden, b.rd);
        chk("beat_wren", o_mem_ext_wren, !b.rd);
        chk("beat_start", o_mem_ext_burst_start, b.st);
        chk("beat_end", o_mem_ext_burst_end, b.en);
        chk("beat_paddr", o_mem_ext_paddr, b.paddr);
        chk("beat_size", o_mem_ext_burst_size, 3'd4);
        if (b.chkd) begin
          chk("beat_wdat", o_mem_ext_wdat, b.wdat);
          chk("beat_mask", o_mem_ext_mask, b.mask);
        end
      end
    end else if (o_mem_ext_burst_vld === 1'b0) begin
      chk("idle_cmd", {o_mem_ext_rden, o_mem_ext_wren, o_mem_ext_burst_start, o_mem_ext_burst_end}, 4'b0);
    end
    if (o_rsp_vld === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        r = rq.pop_front();
        chk("rsp_cyc", cyc, r.cyc);
        chk("rsp_wr", o_rsp_wr, r.wr);
        chk("rsp_err", o_rsp_err, r.err);
        chk("rsp_line", o_rsp_line, r.line);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] ln;
    rst = 1'b1; i_req_vld = 1'b0; i_req_wr = 1'b0; i_req_paddr = '0; i_req_line = '0;
    i_req_mask = '0; i_ext_mmu_rdy = 1'b1; i_ext_mmu_rd_ack = 1'b0; i_ext_mmu_wr_ack = 1'b0;
    i_ext_mmu_rdat = '0;
    repeat (3) tick();
    #3;
    chk("rst_req_rdy", o_req_rdy, 1'b1);
    chk("rst_burst_size", o_mem_ext_burst_size, 3'd4);
    chk("rst_rsp_vld", o_rsp_vld, 1'b0);
    chk("rst_burst_vld", o_mem_ext_burst_vld, 1'b0);
    chk("rst_paddr", o_mem_ext_paddr, 33'h0);
    chk("rst_rsp_line", o_rsp_line, 512'h0);
    tick(); rst = 1'b0;
    tick();

    // Write, ready controller
    t0 = cyc;
    ln = mk_line({32{4'hA}}, {32{4'hB}}, {32{4'hC}}, {32{4'hD}});
    req(1'b1, 33'h1_0000_0047, ln, {64{1'b1}});
    push_wr(t0 + 1, 33'h1_0000_0040, ln, {64{1'b1}}, 4);
    push_rsp(t0 + 8, 1'b1, 1'b0, 512'h0);
    to(t0 + 1); i_req_vld = 1'b0;
    to(t0 + 7); i_ext_mmu_wr_ack = 1'b1;
    to(t0 + 8); i_ext_mmu_wr_ack = 1'b0;
    to(t0 + 10);

    // Read, acks with gaps; a stray wr_ack mid-read must be ignored
    t0 = cyc;
    req(1'b0, 33'h0_1234_5678, '0, '0);
    push_rd(t0 + 1, 33'h0_1234_5640);
    push_rsp(t0 + 8, 1'b0, 1'b0, mk_line(128'd1, 128'd2, 128'd3, 128'd4));
    to(t0 + 1); i_req_vld = 1'b0;
    ack(t0 + 3, 128'd1);
    ack(t0 + 4, 128'd2);
    i_ext_mmu_wr_ack = 1'b1;
    to(t0 + 6); i_ext_mmu_wr_ack = 1'b0;
    ack(t0 + 6, 128'd3);
    ack(t0 + 7, 128'd4);
    to(t0 + 10);

    // Write stalled by rdy=0; rdy dropping after beat 0 must not stall the burst
    t0 = cyc;
    i_ext_mmu_rdy = 1'b0;
    ln = mk_line({4{32'h1111_0000}}, {4{32'h2222_0001}}, {4{32'h3333_0002}}, {4{32'h4444_0003}});
    req(1'b1, 33'h0_0000_1000, ln, 64'h0123_4567_89AB_CDEF);
    push_wr(t0 + 6, 33'h0_0000_1000, ln, 64'h0123_4567_89AB_CDEF, 4);
    push_rsp(t0 + 12, 1'b1, 1'b0, 512'h0);
    for (int c = 1; c <= 9; c++) begin
      to(t0 + c);
      if (c == 1) i_req_vld = 1'b0;
      if (c == 6) i_ext_mmu_rdy = 1'b1;
      if (c == 7) i_ext_mmu_rdy = 1'b0;
      #3;
      chk("stall_req_rdy", o_req_rdy, 1'b0);
    end
    to(t0 + 11); i_ext_mmu_wr_ack = 1'b1;
    to(t0 + 12); i_ext_mmu_wr_ack = 1'b0; i_ext_mmu_rdy = 1'b1;
    to(t0 + 14);

    // Read timeout after two beats: 8 idle cycles then error with upper half zero
    t0 = cyc;
    req(1'b0, 33'h1_FFFF_FFFF, '0, '0);
    push_rd(t0 + 1, 33'h1_FFFF_FFC0);
    push_rsp(t0 + 12, 1'b0, 1'b1, mk_line(128'd5, 128'd6, 128'd0, 128'd0));
    to(t0 + 1); i_req_vld = 1'b0;
    ack(t0 + 2, 128'd5);
    ack(t0 + 3, 128'd6);
    to(t0 + 14);

    // Final ack lands exactly in the expiry cycle: ack wins
    t0 = cyc;
    req(1'b0, 33'h0_0000_0080, '0, '0);
    push_rd(t0 + 1, 33'h0_0000_0080);
    push_rsp(t0 + 13, 1'b0, 1'b0, mk_line(128'hA, 128'hB, 128'hC, 128'hD));
    to(t0 + 1); i_req_vld = 1'b0;
    ack(t0 + 2, 128'hA);
    ack(t0 + 3, 128'hB);
    ack(t0 + 4, 128'hC);
    ack(t0 + 12, 128'hD);
    to(t0 + 15);

    // Reset during beat 2 abandons the write with no response
    t0 = cyc;
    ln = mk_line(128'h10, 128'h20, 128'h30, 128'h40);
    req(1'b1, 33'h0_0000_2000, ln, {64{1'b1}});
    push_wr(t0 + 1, 33'h0_0000_2000, ln, {64{1'b1}}, 3);
    to(t0 + 1); i_req_vld = 1'b0;
    to(t0 + 3); rst = 1'b1;
    to(t0 + 4); rst = 1'b0;
    #3;
    chk("rstmid_burst_vld", o_mem_ext_burst_vld, 1'b0);
    chk("rstmid_cmd", {o_mem_ext_wren, o_mem_ext_rden, o_mem_ext_burst_start, o_mem_ext_burst_end}, 4'b0);
    chk("rstmid_req_rdy", o_req_rdy, 1'b1);
    chk("rstmid_rsp_vld", o_rsp_vld, 1'b0);
    to(t0 + 5); i_ext_mmu_wr_ack = 1'b1; i_ext_mmu_rd_ack = 1'b1;
    #3;
    chk("spurious_req_rdy", o_req_rdy, 1'b1);
    to(t0 + 6); i_ext_mmu_wr_ack = 1'b0; i_ext_mmu_rd_ack = 1'b0;
    #3;
    chk("spurious_rsp_vld", o_rsp_vld, 1'b0);
    chk("spurious_req_rdy2", o_req_rdy, 1'b1);
    to(t0 + 8);

    // Back-to-back reads with i_req_vld held high
    t0 = cyc;
    req(1'b0, 33'h0_0000_0100, '0, '0);
    push_rd(t0 + 1, 33'h0_0000_0100);
    push_rsp(t0 + 6, 1'b0, 1'b0, mk_line(128'h11, 128'h12, 128'h13, 128'h14));
    push_rd(t0 + 8, 33'h0_0000_0240);
    push_rsp(t0 + 13, 1'b0, 1'b0, mk_line(128'h21, 128'h22, 128'h23, 128'h24));
    to(t0 + 1); i_req_paddr = 33'h0_0000_0240;
    #3;
    chk("b2b_busy_req_rdy", o_req_rdy, 1'b0);
    ack(t0 + 2, 128'h11);
    ack(t0 + 3, 128'h12);
    ack(t0 + 4, 128'h13);
    ack(t0 + 5, 128'h14);
    to(t0 + 6); #3;
    chk("b2b_rsp_req_rdy", o_req_rdy, 1'b0);
    to(t0 + 7); #3;
    chk("b2b_idle_req_rdy", o_req_rdy, 1'b1);
    to(t0 + 8); i_req_vld = 1'b0;
    ack(t0 + 9, 128'h21);
    ack(t0 + 10, 128'h22);
    ack(t0 + 11, 128'h23);
    ack(t0 + 12, 128'h24);
    to(t0 + 16);

    chk("beat_queue_empty", bq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmu_ext_burst_ctrl.md
Name: mmu_ext_burst_ctrl

Overview:
Sits directly upstream of the MMU external memory controller and converts whole 512-bit cache-line requests (refill reads, writeback writes) from the MMU/cache side into 4-beat 128-bit bursts on the mem_ext interface. For reads it collects returned beats into a line; for writes it serialises the line. It returns a single response per request, with an error flag on timeout.

Parameters:
PADDR_WIDTH, 33, physical address width
BEAT_WIDTH, 128, data bits per burst beat
TIMEOUT_CYCLES, 255, max cycles waiting for ack/beat before error (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req_vld  in  1  line request valid
o_req_rdy  out  1  block idle and accepting
i_req_wr  in  1  1=writeback, 0=refill
i_req_paddr  in  PADDR_WIDTH  line address; bits [5:0] ignored, forced 0 on output
i_req_line  in  512  write line, beat k = bits [128k+127:128k]
i_req_mask  in  64  byte mask, beat k = bits [16k+15:16k]
o_rsp_vld  out  1  one-cycle response pulse
o_rsp_wr  out  1  echo of request type
o_rsp_err  out  1  timeout occurred
o_rsp_line  out  512  assembled read line (0 for writes)
o_mem_ext_rden  out  1  read command
o_mem_ext_wren  out  1  write command
o_mem_ext_mask  out  16  beat byte mask
o_mem_ext_burst_size  out  3  constant 3'd4
o_mem_ext_paddr  out  PADDR_WIDTH  line-aligned address
o_mem_ext_wdat  out  128  write beat data
o_mem_ext_burst_start  out  1  first beat
o_mem_ext_burst_end  out  1  last beat
o_mem_ext_burst_vld  out  1  beat valid
i_ext_mmu_rdy  in  1  controller idle
i_ext_mmu_rd_ack  in  1  one read beat valid this cycle
i_ext_mmu_wr_ack  in  1  write burst complete
i_ext_mmu_rdat  in  128  read beat data

Behaviour:
- Reset (rst high at posedge): state IDLE, beat counter 0, timeout counter 0, all outputs 0 except o_req_rdy=1 and o_mem_ext_burst_size=3'd4; o_rsp_line cleared. Reset mid-burst abandons it with no response.
- FSM states: IDLE, WR_BEAT, WR_WAIT, RD_CMD, RD_DATA, RSP.
- IDLE: o_req_rdy=1. On i_req_vld: capture paddr (low 6 bits zeroed), line, mask, type; go WR_BEAT if wr else RD_CMD. o_req_rdy=0 in all other states.
- WR_BEAT: drives beat k (2-bit counter from 0) only when i_ext_mmu_rdy=1 at k=0; once started, beats 1..3 issue back-to-back with no stall. Beat k: burst_vld=1, wren=1, wdat/mask = beat k slice, burst_start=(k==0), burst_end=(k==3). After k==3 → WR_WAIT.
- WR_WAIT: wait i_ext_mmu_wr_ack → RSP (err=0).
- RD_CMD: when i_ext_mmu_rdy=1 drive one cycle rden=1, burst_vld=1, burst_start=1, burst_end=0 → RD_DATA, counter=0.
- RD_DATA: each cycle with i_ext_mmu_rd_ack, store rdat into slice k of line buffer, k++; ack on k==3 → RSP. Acks arriving in other states are ignored.
- RSP: o_rsp_vld=1 for exactly one cycle with o_rsp_wr, o_rsp_err, o_rsp_line stable; → IDLE next cycle. o_rsp_line holds until next read response.
- Timeout: counter cleared on every state entry and every accepted ack/beat; increments in RD_CMD, RD_DATA, WR_BEAT(k=0 waiting), WR_WAIT. Reaching TIMEOUT_CYCLES → RSP with err=1; partially filled line returned with unreceived beats zero.
- Write latency: request accepted cycle 0, beats at cycles 1-4 if rdy, response ≥1 cycle after wr_ack. Read: command cycle 1, response the cycle after 4th ack.
- Command outputs (rden/wren/start/end/vld) are 0 whenever not driving a beat/command; paddr/wdat held stable for the whole transaction.
- Simultaneous ack and timeout expiry in the same cycle: the ack wins (no error).

Test Plan:
- Write paddr=0x1_0000_0047, line beats 0xA..A/0xB..B/0xC..C/0xD..D, mask all-1, rdy=1 -> beats at cycles 1-4, paddr out 0x1_0000_0040, start on beat0, end on beat3; wr_ack at cycle 7 -> rsp_vld cycle 8, err=0.
- Read, rdy=1, rd_ack at cycles 3,4,6,7 with data 1,2,3,4 -> rsp_line = {4,3,2,1} at cycle 8, rsp_wr=0.
- Write with rdy=0 for 5 cycles -> no burst_vld until rdy rises, then 4 consecutive beats; o_req_rdy stays 0 throughout.
- Read with only 2 acks, TIMEOUT_CYCLES=8 -> rsp_err=1 after 8 idle cycles, upper 256 bits 0.
- rst asserted during beat 2 of write -> next cycle all command outputs 0, o_req_rdy=1, no rsp_vld.
- Back-to-back requests with i_req_vld held high -> second accepted only the cycle after rsp_vld, spurious wr_ack in IDLE ignored.
